alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one 8-bit ALU datapath between two requesters using round-robin arbitration.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Only one operation is in flight at a time: accept, execute (registered), hold the response until it is taken.
- Sits between the two datapath clients and an internal instance of the team's 10-opcode ALU core.

Parameters:
- WIDTH, 8, operand/result width. Shift amount is 5 bits; rotate uses shiftValue mod WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  2  per-requester request valid (bit i = requester i)
- req_ready  output  2  per-requester request accepted this cycle
- req_opcode  input  8  {opcode1[3:0], opcode0[3:0]}
- req_input1  input  2*WIDTH  {r1, r0} operand A
- req_input2  input  2*WIDTH  {r1, r0} operand B
- req_shiftValue  input  10  {r1[4:0], r0[4:0]}
- rsp_valid  output  2  response valid, one-hot or zero
- rsp_ready  input  2  response consumed
- rsp_result  output  WIDTH  result of the in-flight op (shared bus)
- rsp_carryFlag, rsp_zeroFlag, rsp_overFlowFlag  output  1 each  flags of the in-flight op

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE, rr_ptr=0 (requester 0 favoured).
  - rsp_valid=0, rsp_result=0, all flags=0.
  - Captured operands cleared.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - grant = the rr_ptr requester if its req_valid is high, else the other requester if valid.
  - req_ready[grant]=1 combinationally, only in IDLE. req_ready is otherwise 0.
  - On handshake: capture opcode, operands, shiftValue and grant index; go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC: register the ALU outputs into rsp_* and go to RESP.
- RESP:
  - rsp_valid[gidx]=1, with rsp_result and flags held stable.
  - On rsp_ready[gidx]: go to IDLE and set rr_ptr = ~gidx.
  - rsp_ready on the non-granted bit is ignored.
- Latency and throughput:
  - Request accepted in cycle N -> rsp_valid in cycle N+2.
  - Minimum 3 cycles per operation.
- Both requesters valid in IDLE: the rr_ptr requester wins. Alternation is strict under continuous load.
- req_valid may drop without a handshake; the request is simply not issued.
- Reset mid-operation: the in-flight op is discarded with no response. Next cycle is IDLE with rr_ptr=0.
- ALU core semantics (opcode: result / carry / overflow):
  - 0 ROR: input1 rotated right by shiftValue%WIDTH / 0 / 0
  - 1 ADD: low WIDTH bits of input1+input2 / bit WIDTH of the sum / signed overflow (same operand signs, result sign differs)
  - 2 XOR / 0 / 0
  - 3 NAND / 0 / 0
  - 4 SUB: input1-input2 / borrow (input1<input2 unsigned) / signed overflow (operand signs differ, result sign differs from input1)
  - 5 SGT: 1 if signed input1>input2, else 0 / 0 / 0
  - 6 SEQ: 1 if equal, else 0 / 0 / 0
  - 7 XNOR / 0 / 0
  - 8 MAX: unsigned maximum / 0 / 0
  - 9 PASSB: input2 / 0 / 0
  - 10-15: result 0 / 0 / 0
  - zeroFlag = (result==0) for every opcode, including 10-15.
  - The core is fully combinational and assigns every output on every path: no latches, no undeclared signals.

Optional Feature:
- Macro: ALU_RR_SCHEDULER_STATS_EN.
- Defined:
  - Adds output port op_count[15:0].
  - Increments by 1 on each response handshake (rsp_valid & rsp_ready).
  - Saturates at 16'hFFFF. Cleared by rst.
- Not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants ROR=4'd0 ... PASSB=4'd9.
  - Scheduler state enum {IDLE, EXEC, RESP}.
  - Default WIDTH=8.
- One sub-module: alu_core (combinational, WIDTH-parameterised). Ports: opcode, input1, input2, shiftValue, result, carryFlag, zeroFlag, overFlowFlag.
- alu_rr_scheduler instantiates alu_core once.

Test Plan:
- Reset then idle: all outputs 0, req_ready=0 with no request. Assert rst in RESP -> rsp_valid=0 next cycle.
- req0 ADD 8'hFF+8'h01 accepted at cycle N -> rsp_valid=2'b01 at N+2, result 8'h00, carry 1, zero 1, overflow 0.
- req1 SUB 8'h80-8'h01 -> result 8'h7F, carry 0, overflow 1. ROR 8'h81 by 5'd9 -> 8'hC0.
- Both valid continuously with rsp_ready=2'b11 -> grants alternate 0,1,0,1. Each op takes 3 cycles.
- RESP with rsp_ready held 0 for 5 cycles -> result and flags stable, req_ready=0. Release -> IDLE next cycle.
- SGT 8'hFF vs 8'h01 -> result 0. SEQ 8'h3C vs 8'h3C -> result 1. Opcode 4'd12 -> result 0, zero 1. STATS_EN build: op_count equals handshake count.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, scheduler state type and default datapath width
package alu_pkg;
  localparam int ALU_WIDTH = 8;
  localparam logic [3:0] ROR   = 4'd0;
  localparam logic [3:0] ADD   = 4'd1;
  localparam logic [3:0] XOR   = 4'd2;
  localparam logic [3:0] NAND  = 4'd3;
  localparam logic [3:0] SUB   = 4'd4;
  localparam logic [3:0] SGT   = 4'd5;
  localparam logic [3:0] SEQ   = 4'd6;
  localparam logic [3:0] XNOR  = 4'd7;
  localparam logic [3:0] MAX   = 4'd8;
  localparam logic [3:0] PASSB = 4'd9;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 10-opcode ALU
// ports: opcode, input1/input2 operands, shiftValue rotate amount -> result, carry/zero/overflow flags
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [4:0]       shiftValue,
  output logic [WIDTH-1:0] result,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             overFlowFlag
);
  logic [WIDTH:0]     sum, dif;
  logic [2*WIDTH-1:0] rot;
  logic [4:0]         amt;
  always_comb begin
    amt = shiftValue % 5'(WIDTH);
    // rotate right: shift a doubled copy so wrapped bits land in the low half
    rot = {input1, input1} >> amt;
    sum = {1'b0, input1} + {1'b0, input2};
    dif = {1'b0, input1} - {1'b0, input2};
    result = '0;
    carryFlag = 1'b0;
    overFlowFlag = 1'b0;
    case (opcode)
      ROR:   result = rot[WIDTH-1:0];
      ADD: begin
        result = sum[WIDTH-1:0];
        carryFlag = sum[WIDTH];
        overFlowFlag = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
      end
      XOR:   result = input1 ^ input2;
      NAND:  result = ~(input1 & input2);
      SUB: begin
        result = dif[WIDTH-1:0];
        carryFlag = dif[WIDTH];
        overFlowFlag = (input1[WIDTH-1] != input2[WIDTH-1]) && (dif[WIDTH-1] != input1[WIDTH-1]);
      end
      SGT:   result = WIDTH'($signed(input1) > $signed(input2));
      SEQ:   result = WIDTH'(input1 == input2);
      XNOR:  result = ~(input1 ^ input2);
      MAX:   result = input1 > input2 ? input1 : input2;
      PASSB: result = input2;
      default: result = '0;
    endcase
    zeroFlag = result == '0;
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one alu_core between two valid/ready requesters
// ports: req_valid/req_ready + packed {r1,r0} opcode/operands/shiftValue in; rsp_valid/rsp_ready,
// shared rsp_result and flags out; op_count (response handshakes, saturating) when ALU_RR_SCHEDULER_STATS_EN
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [7:0]         req_opcode,
  input  logic [2*WIDTH-1:0] req_input1,
  input  logic [2*WIDTH-1:0] req_input2,
  input  logic [9:0]         req_shiftValue,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_carryFlag,
  output logic               rsp_zeroFlag,
  output logic               rsp_overFlowFlag
`ifdef ALU_RR_SCHEDULER_STATS_EN
  ,
  output logic [15:0]        op_count
`endif
);
  state_t           state_q, state_d;
  logic             rr_q, rr_d, gidx_q, gidx_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [4:0]       sh_q, sh_d;
  logic             c_q, c_d, z_q, z_d, v_q, v_d;
  logic             grant, rsp_hs;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_z, alu_v;
`ifdef ALU_RR_SCHEDULER_STATS_EN
  logic [15:0]      cnt_q, cnt_d;
`endif
  alu_core #(.WIDTH(WIDTH)) u_core (
    .opcode      (op_q),
    .input1      (a_q),
    .input2      (b_q),
    .shiftValue  (sh_q),
    .result      (alu_res),
    .carryFlag   (alu_c),
    .zeroFlag    (alu_z),
    .overFlowFlag(alu_v)
  );
  always_comb begin
    // favoured requester wins, otherwise fall back to the other one
    grant = req_valid[rr_q] ? rr_q : ~rr_q;
    req_ready = (state_q == IDLE && |req_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = state_q == RESP ? (gidx_q ? 2'b10 : 2'b01) : 2'b00;
    rsp_hs = state_q == RESP && rsp_ready[gidx_q];
    state_d = state_q;
    rr_d = rr_q;
    gidx_d = gidx_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    sh_d = sh_q;
    res_d = res_q;
    c_d = c_q;
    z_d = z_q;
    v_d = v_q;
    if (|req_ready) begin
      state_d = EXEC;
      gidx_d = grant;
      op_d = grant ? req_opcode[7:4] : req_opcode[3:0];
      a_d = grant ? req_input1[2*WIDTH-1:WIDTH] : req_input1[WIDTH-1:0];
      b_d = grant ? req_input2[2*WIDTH-1:WIDTH] : req_input2[WIDTH-1:0];
      sh_d = grant ? req_shiftValue[9:5] : req_shiftValue[4:0];
    end
    if (state_q == EXEC) begin
      state_d = RESP;
      res_d = alu_res;
      c_d = alu_c;
      z_d = alu_z;
      v_d = alu_v;
    end
    if (rsp_hs) begin
      state_d = IDLE;
      rr_d = ~gidx_q;
    end
  end
`ifdef ALU_RR_SCHEDULER_STATS_EN
  assign cnt_d = (rsp_hs && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  assign op_count = cnt_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      gidx_q <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sh_q <= '0;
      res_q <= '0;
      c_q <= 1'b0;
      z_q <= 1'b0;
      v_q <= 1'b0;
`ifdef ALU_RR_SCHEDULER_STATS_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      gidx_q <= gidx_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      sh_q <= sh_d;
      res_q <= res_d;
      c_q <= c_d;
      z_q <= z_d;
      v_q <= v_d;
`ifdef ALU_RR_SCHEDULER_STATS_EN
      cnt_q <= cnt_d;
`endif
    end
  end
  assign rsp_result = res_q;
  assign rsp_carryFlag = c_q;
  assign rsp_zeroFlag = z_q;
  assign rsp_overFlowFlag = v_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed vector table plus arbitration, stall and reset sequences
module tb_alu_rr_scheduler;
  import alu_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00, req_ready, rsp_valid, rsp_ready = 2'b00;
  logic [7:0]  req_opcode = '0;
  logic [15:0] req_input1 = '0, req_input2 = '0;
  logic [9:0]  req_shiftValue = '0;
  logic [7:0]  rsp_result;
  logic        rsp_carryFlag, rsp_zeroFlag, rsp_overFlowFlag;
  int          n_cmp = 0, n_bad = 0;
`ifdef ALU_RR_SCHEDULER_STATS_EN
  logic [15:0] op_count;
  int          hs_cnt = 0;
  always @(posedge clk) hs_cnt <= rst ? 0 : hs_cnt + int'(|(rsp_valid & rsp_ready));
`endif
  alu_rr_scheduler #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_input1(req_input1), .req_input2(req_input2),
    .req_shiftValue(req_shiftValue),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carryFlag(rsp_carryFlag), .rsp_zeroFlag(rsp_zeroFlag), .rsp_overFlowFlag(rsp_overFlowFlag)
`ifdef ALU_RR_SCHEDULER_STATS_EN
    , .op_count(op_count)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  typedef struct {
    int         r;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [4:0] sh;
    logic [7:0] er;
    logic       ec, ez, ev;
  } vec_t;
  vec_t vt[16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input vec_t v, input string tag);
    logic [1:0] oh;
    int t;
    oh = v.r != 0 ? 2'b10 : 2'b01;
    // the idle slot carries inverted values so a wrong lane select shows up
    req_opcode = v.r != 0 ? {v.op, ~v.op} : {~v.op, v.op};
    req_input1 = v.r != 0 ? {v.a, ~v.a} : {~v.a, v.a};
    req_input2 = v.r != 0 ? {v.b, ~v.b} : {~v.b, v.b};
    req_shiftValue = v.r != 0 ? {v.sh, ~v.sh} : {~v.sh, v.sh};
    req_valid = oh;
    rsp_ready = 2'b00;
    #1;
    t = 0;
    while (req_ready != oh && t < 10) begin
      step();
      t++;
    end
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(oh));
    step();
    req_valid = 2'b00;
    chk({tag, ".exec_rsp_valid"}, 32'(rsp_valid), 0);
    step();
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(oh));
    chk({tag, ".result"}, 32'(rsp_result), 32'(v.er));
    chk({tag, ".carry"}, 32'(rsp_carryFlag), 32'(v.ec));
    chk({tag, ".zero"}, 32'(rsp_zeroFlag), 32'(v.ez));
    chk({tag, ".overflow"}, 32'(rsp_overFlowFlag), 32'(v.ev));
    rsp_ready = oh;
    step();
    rsp_ready = 2'b00;
    chk({tag, ".done_rsp_valid"}, 32'(rsp_valid), 0);
  endtask
  initial begin
    logic [1:0] g;
    vt[0]  = '{0, ADD,   8'hFF, 8'h01, 5'd0,  8'h00, 1'b1, 1'b1, 1'b0};
    vt[1]  = '{1, SUB,   8'h80, 8'h01, 5'd0,  8'h7F, 1'b0, 1'b0, 1'b1};
    vt[2]  = '{0, ROR,   8'h81, 8'h00, 5'd9,  8'hC0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1, SGT,   8'hFF, 8'h01, 5'd0,  8'h00, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{0, SEQ,   8'h3C, 8'h3C, 5'd0,  8'h01, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1, 4'd12, 8'h55, 8'hAA, 5'd3,  8'h00, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{0, ADD,   8'h7F, 8'h01, 5'd0,  8'h80, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{1, SUB,   8'h01, 8'h02, 5'd0,  8'hFF, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{0, XOR,   8'hA5, 8'h5A, 5'd0,  8'hFF, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1, NAND,  8'hF0, 8'h3C, 5'd0,  8'hCF, 1'b0, 1'b0, 1'b0};
    vt[10] = '{0, XNOR,  8'hF0, 8'h3C, 5'd0,  8'h33, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1, MAX,   8'h7F, 8'h80, 5'd0,  8'h80, 1'b0, 1'b0, 1'b0};
    vt[12] = '{0, PASSB, 8'h11, 8'h00, 5'd0,  8'h00, 1'b0, 1'b1, 1'b0};
    vt[13] = '{1, ROR,   8'h01, 8'h00, 5'd0,  8'h01, 1'b0, 1'b0, 1'b0};
    vt[14] = '{0, ROR,   8'h01, 8'h00, 5'd31, 8'h02, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1, SGT,   8'h01, 8'hFF, 5'd0,  8'h01, 1'b0, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.rsp_valid", 32'(rsp_valid), 0);
    chk("reset.req_ready", 32'(req_ready), 0);
    chk("reset.result", 32'(rsp_result), 0);
    chk("reset.flags", 32'({rsp_carryFlag, rsp_zeroFlag, rsp_overFlowFlag}), 0);
    step();
    chk("idle.req_ready", 32'(req_ready), 0);
    for (int i = 0; i < 16; i++) run_op(vt[i], $sformatf("vec%0d", i));
    // continuous load from both sides after reset: grants go 0,1,0,1, three cycles each
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_opcode = {XOR, ADD};
    req_input1 = {8'h0F, 8'h10};
    req_input2 = {8'hF0, 8'h05};
    req_shiftValue = '0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 12; k++) begin
      g = ((k / 3) % 2) != 0 ? 2'b10 : 2'b01;
      if (k % 3 == 0) chk($sformatf("rr%0d.grant", k), 32'(req_ready), 32'(g));
      if (k % 3 == 1) chk($sformatf("rr%0d.exec", k), 32'({req_ready, rsp_valid}), 0);
      if (k % 3 == 2) begin
        chk($sformatf("rr%0d.rsp_valid", k), 32'(rsp_valid), 32'(g));
        chk($sformatf("rr%0d.result", k), 32'(rsp_result), g == 2'b01 ? 32'h15 : 32'hFF);
      end
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    // response stall with a pending request from the other side and a stray ready
    req_opcode = {PASSB, ADD};
    req_input1 = {8'h00, 8'h12};
    req_input2 = {8'h00, 8'h34};
    req_valid = 2'b01;
    #1;
    chk("stall.req_ready", 32'(req_ready), 32'(2'b01));
    step();
    req_valid = 2'b10;
    step();
    rsp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d.rsp_valid", k), 32'(rsp_valid), 32'(2'b01));
      chk($sformatf("stall%0d.result", k), 32'(rsp_result), 32'h46);
      chk($sformatf("stall%0d.flags", k), 32'({rsp_carryFlag, rsp_zeroFlag, rsp_overFlowFlag}), 0);
      chk($sformatf("stall%0d.req_ready", k), 32'(req_ready), 0);
      step();
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("release.rsp_valid", 32'(rsp_valid), 0);
    chk("release.req_ready", 32'(req_ready), 32'(2'b10));
    req_valid = 2'b00;
    step();
    chk("drop.req_ready", 32'(req_ready), 0);
    chk("drop.rsp_valid", 32'(rsp_valid), 0);
`ifdef ALU_RR_SCHEDULER_STATS_EN
    chk("stats.op_count", 32'(op_count), 32'(hs_cnt));
`endif
    // reset while requester 1 waits in RESP: response dropped, pointer back to 0
    req_opcode = {ADD, ADD};
    req_input1 = {8'h01, 8'h01};
    req_input2 = {8'h01, 8'h01};
    req_valid = 2'b10;
    #1;
    chk("rstresp.req_ready", 32'(req_ready), 32'(2'b10));
    step();
    req_valid = 2'b00;
    step();
    chk("rstresp.rsp_valid", 32'(rsp_valid), 32'(2'b10));
    chk("rstresp.result", 32'(rsp_result), 32'h02);
    rst = 1'b1;
    step();
    chk("rstresp.after_valid", 32'(rsp_valid), 0);
    chk("rstresp.after_result", 32'(rsp_result), 0);
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rstresp.rr_ptr", 32'(req_ready), 32'(2'b01));
    req_valid = 2'b00;
    step();
`ifdef ALU_RR_SCHEDULER_STATS_EN
    chk("stats.cleared", 32'(op_count), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
